result_serializer: RTL and testbench

- Sits between the ALU result bus and the TX byte transmitter.
- Captures a 32-bit result on a start pulse and sends it as NBYTES bytes, LSB byte first by default.
- Drives TX with a tx_start/tx_done handshake, one byte at a time.
- Reports completion with a done pulse, or a timeout with an error pulse when TX stops responding.

---
 rtl/result_serializer_pkg.sv | 21 ++
 rtl/result_serializer_timeout_counter.sv | 46 ++++
 rtl/result_serializer.sv | 158 +++++++++++++++
 tb/tb_result_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// ---------------------------------------------------------------------------
// result_serializer_pkg
// Shared definitions for the result serializer and its bench:
//   - state_t          : FSM state encoding (IDLE, SEND, WAIT, DONE, ERR)
//   - BYTE_W           : width of one transmitted byte
//   - DEFAULT_TIMEOUT  : default watchdog limit in clk cycles
// ---------------------------------------------------------------------------
package result_serializer_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 1000000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/result_serializer_timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
// Loadable saturating up-counter used as a watchdog.
// Ports:
//   i_clk      in   clock, rising edge
//   i_rst      in   asynchronous active-high reset, clears the count
//   i_clr      in   synchronous clear (highest priority)
//   i_load     in   synchronous load of i_load_val
//   i_load_val in   W  value for i_load
//   i_en       in   count enable; the count sticks at all-ones
//   o_expired  out  high while count >= LIMIT
// ---------------------------------------------------------------------------
module timeout_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    localparam logic [W-1:0] MAX_CNT = '1;
    localparam logic [W-1:0] LIM     = W'(LIMIT);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != MAX_CNT)) begin
            // Saturate instead of wrapping so an expired watchdog stays expired.
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count >= LIM);

endmodule

// File: rtl/result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
// Captures an ALU result word on start and hands it to the TX byte
// transmitter one byte at a time using a tx_start/tx_done handshake.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   start     in   one-cycle request, honoured only in IDLE
//   data_in   in   8*NBYTES result word, captured with an accepted start
//   tx_done   in   one-cycle pulse from TX: current byte finished
//   tx_data   out  8  byte presented to TX
//   tx_start  out  one-cycle pulse: TX loads tx_data
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse: whole word sent
//   error     out  one-cycle pulse: watchdog expired, frame aborted
// ---------------------------------------------------------------------------
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int NBYTES    = 4,
    parameter int LSB_FIRST = 1,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BYTE_W*NBYTES-1:0]   data_in,
    input  logic                       tx_done,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_start,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int DATA_W   = BYTE_W * NBYTES;
    localparam int CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LIMIT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    // Byte that sits at the send end of the shift register.
    function automatic logic [BYTE_W-1:0] send_byte(input logic [DATA_W-1:0] w);
        if (LSB_FIRST != 0) return w[BYTE_W-1:0];
        else                return w[DATA_W-1 -: BYTE_W];
    endfunction

    // Move the next byte into the send end.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        if (LSB_FIRST != 0) return w >> BYTE_W;
        else                return w << BYTE_W;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                w_wd_clr;
    logic                w_wd_en;
    logic                w_wd_expired;
    logic                w_timeout;

    timeout_counter #(
        .W     (WD_W),
        .LIMIT (WD_LIMIT)
    ) u_watchdog (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clr      (w_wd_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_wd_en),
        .o_expired  (w_wd_expired)
    );

    // TIMEOUT == 0 disables the watchdog entirely.
    assign w_timeout = (TIMEOUT != 0) ? w_wd_expired : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_wd_clr    = 1'b0;
        w_wd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_SEND;
                    w_shift_nxt = data_in;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SEND: begin
                w_next   = ST_WAIT;
                w_wd_clr = 1'b1;
            end
            ST_WAIT: begin
                w_wd_en = 1'b1;
                // tx_done takes priority over a coincident timeout.
                if (tx_done) begin
                    if (r_cnt == LAST_CNT) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next      = ST_SEND;
                        w_shift_nxt = shift_out(r_shift);
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any combinational path to the ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_start <= (w_next == ST_SEND);
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERR);
            if (w_next == ST_SEND) r_tx_data <= send_byte(w_shift_nxt);
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_result_serializer
// Directed bench for result_serializer. Three instances share clk/reset and
// the start/tx_done strobes:
//   u_a   : NBYTES=4, LSB first, TIMEOUT=50
//   u_m   : NBYTES=4, MSB first, default TIMEOUT
//   u_one : NBYTES=1, LSB first, TIMEOUT=50
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_serializer;
    import result_serializer_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        tx_done;
    logic [31:0] data_in;
    logic [7:0]  data8;

    logic [7:0]  a_tx_data, m_tx_data, o_tx_data;
    logic        a_tx_start, m_tx_start, o_tx_start;
    logic        a_busy, m_busy, o_busy;
    logic        a_done, m_done, o_done;
    logic        a_error, m_error, o_error;

    int checks   = 0;
    int failures = 0;

    result_serializer #(.NBYTES(4), .LSB_FIRST(1), .TIMEOUT(50)) u_a (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .tx_done(tx_done),
        .tx_data(a_tx_data), .tx_start(a_tx_start), .busy(a_busy), .done(a_done), .error(a_error)
    );

    result_serializer #(.NBYTES(4), .LSB_FIRST(0), .TIMEOUT(DEFAULT_TIMEOUT)) u_m (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .tx_done(tx_done),
        .tx_data(m_tx_data), .tx_start(m_tx_start), .busy(m_busy), .done(m_done), .error(m_error)
    );

    result_serializer #(.NBYTES(1), .LSB_FIRST(1), .TIMEOUT(50)) u_one (
        .clk(clk), .reset(reset), .start(start), .data_in(data8), .tx_done(tx_done),
        .tx_data(o_tx_data), .tx_start(o_tx_start), .busy(o_busy), .done(o_done), .error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete frame through u_a (and u_m when chk_m), TX answering
    // gap cycles after each tx_start.
    task automatic frame(input logic [31:0] d, input int gap, input bit chk_m,
                         input bit bump, input bit start_in_done);
        start   = 1'b1;
        data_in = d;
        tick();
        start   = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk("a_tx_start", {31'd0, a_tx_start}, 32'd1);
            chk("a_tx_data", {24'd0, a_tx_data}, {24'd0, d[8*b +: 8]});
            if (chk_m) chk("m_tx_data", {24'd0, m_tx_data}, {24'd0, d[8*(3-b) +: 8]});
            tick();
            chk("a_tx_start_pulse", {31'd0, a_tx_start}, 32'd0);
            for (int k = 0; k < gap - 1; k++) begin
                if (bump && b == 1 && k == 0) begin
                    start   = 1'b1;
                    data_in = 32'h12345678;
                end
                tick();
                start = 1'b0;
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        chk("a_done", {31'd0, a_done}, 32'd1);
        chk("a_busy_in_done", {31'd0, a_busy}, 32'd1);
        chk("a_no_error", {31'd0, a_error}, 32'd0);
        if (chk_m) chk("m_done", {31'd0, m_done}, 32'd1);
        if (start_in_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_done_pulse", {31'd0, a_done}, 32'd0);
        chk("a_busy_after_done", {31'd0, a_busy}, 32'd0);
        if (start_in_done) begin
            chk("a_start_in_done_dropped", {31'd0, a_tx_start}, 32'd0);
            tick();
            chk("a_start_in_done_still_idle", {31'd0, a_tx_start | a_busy}, 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL tb_global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic acc;
        reset   = 1'b0;
        start   = 1'b0;
        tx_done = 1'b0;
        data_in = '0;
        data8   = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_a_outputs", {a_tx_data, 20'd0, a_tx_start, a_busy, a_done, a_error}, 32'd0);
        chk("rst_m_outputs", {m_tx_data, 20'd0, m_tx_start, m_busy, m_done, m_error}, 32'd0);
        chk("rst_one_outputs", {o_tx_data, 20'd0, o_tx_start, o_busy, o_done, o_error}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic send: A gives EF BE AD DE, M gives DE AD BE EF.
        frame(32'hDEADBEEF, 10, 1'b1, 1'b0, 1'b0);
        // Started the cycle after done; M checks 01 02 03 04.
        frame(32'h01020304, 10, 1'b1, 1'b0, 1'b0);
        // Start mid-frame and in the DONE cycle are both dropped.
        frame(32'hDEADBEEF, 10, 1'b1, 1'b1, 1'b1);
        // Back-to-back tx_done: done lands at t+9.
        frame(32'hCAFEF00D, 1, 1'b1, 1'b0, 1'b0);

        // Timeout on u_a: TX never answers.
        data_in = 32'h55AA55AA;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("to_tx_start", {31'd0, a_tx_start}, 32'd1);
        chk("to_tx_data", {24'd0, a_tx_data}, 32'h000000AA);
        acc = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            acc = acc | a_error | a_done | ~a_busy;
        end
        chk("to_no_early_end", {31'd0, acc}, 32'd0);
        tick();
        chk("to_error", {31'd0, a_error}, 32'd1);
        chk("to_busy_in_err", {31'd0, a_busy}, 32'd1);
        chk("to_no_done", {31'd0, a_done}, 32'd0);
        tick();
        chk("to_error_pulse", {31'd0, a_error}, 32'd0);
        chk("to_busy_fall", {31'd0, a_busy}, 32'd0);
        frame(32'h11223344, 10, 1'b0, 1'b0, 1'b0);

        // Reset during byte 2.
        data_in = 32'h0A0B0C0D;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int b = 0; b < 2; b++) begin
            tick();
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        chk("rmf_byte2_start", {31'd0, a_tx_start}, 32'd1);
        chk("rmf_byte2_data", {24'd0, a_tx_data}, 32'h0000000B);
        tick();
        chk("rmf_busy_before", {31'd0, a_busy}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("rmf_outputs_clear", {a_tx_data, 20'd0, a_tx_start, a_busy, a_done, a_error}, 32'd0);
        #1 reset = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            acc = acc | a_tx_start | a_done | a_busy;
            tick();
        end
        chk("rmf_stray_tx_done_ignored", {31'd0, acc}, 32'd0);

        // Single-byte instance.
        data8   = 8'hA5;
        data_in = 32'h0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("one_tx_start", {31'd0, o_tx_start}, 32'd1);
        chk("one_tx_data", {24'd0, o_tx_data}, 32'h000000A5);
        tick();
        chk("one_tx_start_pulse", {31'd0, o_tx_start}, 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("one_done", {31'd0, o_done}, 32'd1);
        chk("one_no_second_byte", {31'd0, o_tx_start}, 32'd0);
        tick();
        chk("one_idle", {30'd0, o_busy, o_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
